// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - handshaked multi-cycle data memory responder
//
// Purpose:
//    Serves CPU data loads and stores from a DEPTH x DW register array.
//    A request is accepted in IDLE and its fields are latched. LATENCY wait
//    states follow, then the access is performed, and a one-cycle ack
//    completes the transaction.
//
// Optional feature (macro DMEM_OOR_ERR_EN):
//    When defined, an address >= DEPTH is out of range. Such a store does not
//    write, such a load returns 0, and err is raised during the ack cycle.
//    When undefined, the address wraps modulo DEPTH and err is tied to 0.
//
// Ports:
//    clk    in   rising-edge clock
//    rst    in   asynchronous active-low reset
//    req    in   request level, held with we/addr/wdata until ack
//    we     in   1 = store, 0 = load
//    addr   in   16-bit word address
//    wdata  in   store data
//    ack    out  one-cycle completion pulse
//    rdata  out  load data, held until the next load completes
//    busy   out  high while in WAIT or RESP
//    err    out  out-of-range flag, qualified by ack

module dmem_responder #(
   parameter int DEPTH   = 128,
   parameter int LATENCY = 2,
   parameter int DW      = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req,
   input  logic          we,
   input  logic [15:0]   addr,
   input  logic [DW-1:0] wdata,
   output logic          ack,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic          err
);

   localparam int         AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] LAT = 4'(LATENCY);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [AW-1:0]  idx_q;
   logic           we_q;
   logic [DW-1:0]  wdata_q;
   logic           oor_q;
   logic [DW-1:0]  rdata_q;
   logic [DW-1:0]  mem_q [DEPTH];

   logic           accept;
   logic           access;
   logic           addr_oor;

   // Upper address bits only matter for the range check; otherwise they are
   // discarded and the index wraps.
   logic           unused_addr_hi;
   assign unused_addr_hi = ^addr[15:AW];

`ifdef DMEM_OOR_ERR_EN
   localparam logic [16:0] DEPTH_L = 17'(DEPTH);
   assign addr_oor = ({1'b0, addr} >= DEPTH_L);
`else
   assign addr_oor = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      access  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               accept  = 1'b1;
               cnt_d   = LAT;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               access  = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Request fields are captured once at acceptance; inputs are ignored
   // for the rest of the transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q   <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         oor_q   <= 1'b0;
      end else if (accept) begin
         idx_q   <= addr[AW-1:0];
         we_q    <= we;
         wdata_q <= wdata;
         oor_q   <= addr_oor;
      end
   end

   // Storage array, cleared by reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (access && we_q && !oor_q) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   // Load data register; stores leave it untouched
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q <= '0;
      end else if (access && !we_q) begin
         rdata_q <= oor_q ? '0 : mem_q[idx_q];
      end
   end

   assign ack   = (state_q == ST_RESP);
   assign busy  = (state_q != ST_IDLE);
   assign rdata = rdata_q;

`ifdef DMEM_OOR_ERR_EN
   assign err = ack && oor_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - table-driven bench for dmem_responder

module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        req,  we;
   logic [15:0] addr, wdata;
   logic        ack,  busy, err;
   logic [15:0] rdata;

   logic        req0,  we0;
   logic [15:0] addr0, wdata0;
   logic        ack0,  busy0, err0;
   logic [15:0] rdata0;

   int checks = 0;
   int errors = 0;

`ifdef DMEM_OOR_ERR_EN
   localparam bit OOR = 1'b1;
`else
   localparam bit OOR = 1'b0;
`endif

   dmem_responder #(.DEPTH(128), .LATENCY(2), .DW(16)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .rdata(rdata), .busy(busy), .err(err)
   );

   dmem_responder #(.DEPTH(128), .LATENCY(0), .DW(16)) dut0 (
      .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
      .ack(ack0), .rdata(rdata0), .busy(busy0), .err(err0)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        w;
      logic [15:0] a;
      logic [15:0] d;
      logic [15:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vt [11];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic logic ack_of(input bit s);
      return s ? ack0 : ack;
   endfunction

   function automatic logic busy_of(input bit s);
      return s ? busy0 : busy;
   endfunction

   function automatic logic err_of(input bit s);
      return s ? err0 : err;
   endfunction

   function automatic logic [15:0] rdata_of(input bit s);
      return s ? rdata0 : rdata;
   endfunction

   task automatic drive(input bit s, input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
      if (s) begin
         req0 = r; we0 = w; addr0 = a; wdata0 = d;
      end else begin
         req = r; we = w; addr = a; wdata = d;
      end
   endtask

   // One transaction: lat = negedges after the acceptance edge until ack is seen,
   // bsy = negedge samples with busy high up to and including the ack cycle.
   task automatic txn(input bit s, input logic w, input logic [15:0] a, input logic [15:0] d,
                      output logic [15:0] rd, output logic e, output int lat, output int bsy,
                      output logic ack_after);
      @(negedge clk);
      drive(s, 1'b1, w, a, d);
      lat = 0; bsy = 0; rd = '0; e = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (busy_of(s)) bsy++;
         if (ack_of(s)) begin
            lat = n;
            rd  = rdata_of(s);
            e   = err_of(s);
            break;
         end
      end
      drive(s, 1'b0, w, a, d);
      @(negedge clk);
      ack_after = ack_of(s) | busy_of(s);
   endtask

   logic [15:0] rd;
   logic        e, aa;
   int          lat, bsy;

   initial begin
      drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);

      vt[0]  = '{1'b0, 16'd5,   16'h0000, 16'h0000, 1'b0};
      vt[1]  = '{1'b1, 16'd10,  16'h9789, 16'h0000, 1'b0};
      vt[2]  = '{1'b0, 16'd10,  16'h0000, 16'h9789, 1'b0};
      vt[3]  = '{1'b1, 16'd3,   16'h0031, 16'h9789, 1'b0};
      vt[4]  = '{1'b0, 16'd3,   16'h0000, 16'h0031, 1'b0};
      vt[5]  = '{1'b1, 16'd130, 16'hBEEF, 16'h0031, OOR};
      vt[6]  = '{1'b0, 16'd2,   16'h0000, OOR ? 16'h0000 : 16'hBEEF, 1'b0};
      vt[7]  = '{1'b0, 16'd130, 16'h0000, OOR ? 16'h0000 : 16'hBEEF, OOR};
      vt[8]  = '{1'b1, 16'd127, 16'hA5A5, OOR ? 16'h0000 : 16'hBEEF, 1'b0};
      vt[9]  = '{1'b0, 16'd127, 16'h0000, 16'hA5A5, 1'b0};
      vt[10] = '{1'b0, 16'd255, 16'h0000, OOR ? 16'h0000 : 16'hA5A5, OOR};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst ack",   ack,   1'b0);
      check("rst busy",  busy,  1'b0);
      check("rst rdata", rdata, 16'h0000);
      check("rst err",   err,   1'b0);
      check("rst ack0",  ack0,  1'b0);
      check("rst busy0", busy0, 1'b0);
      rst = 1'b1;

      // Table-driven transactions on the LATENCY=2 instance
      for (int i = 0; i < 11; i++) begin
         txn(1'b0, vt[i].w, vt[i].a, vt[i].d, rd, e, lat, bsy, aa);
         check($sformatf("v%0d latency", i), lat, 4);
         check($sformatf("v%0d busy_cycles", i), bsy, 4);
         check($sformatf("v%0d rdata", i), rd, vt[i].exp_rd);
         check($sformatf("v%0d err", i), e, vt[i].exp_err);
         check($sformatf("v%0d idle_after", i), aa, 1'b0);
      end

      // Back-to-back with req held: two acks five cycles apart
      begin
         int          first, second, nack;
         logic [15:0] r1, r2;
         first = -1; second = -1; nack = 0; r1 = '0; r2 = '0;
         @(negedge clk);
         drive(1'b0, 1'b1, 1'b0, 16'd3, 16'h0);
         for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ack) begin
               nack++;
               if (nack == 1) begin
                  first = n; r1 = rdata;
               end else if (nack == 2) begin
                  second = n; r2 = rdata;
                  drive(1'b0, 1'b0, 1'b0, 16'd3, 16'h0);
               end
            end
         end
         drive(1'b0, 1'b0, 1'b0, 16'd3, 16'h0);
         check("b2b ack_count", nack, 2);
         check("b2b first_lat", first, 4);
         check("b2b spacing", second - first, 5);
         check("b2b rdata1", r1, 16'h0031);
         check("b2b rdata2", r2, 16'h0031);
      end

      // LATENCY=0 instance
      txn(1'b1, 1'b1, 16'd1, 16'h0023, rd, e, lat, bsy, aa);
      check("lat0 store latency", lat, 2);
      check("lat0 store rdata", rd, 16'h0000);
      txn(1'b1, 1'b0, 16'd1, 16'h0000, rd, e, lat, bsy, aa);
      check("lat0 load latency", lat, 2);
      check("lat0 load busy_cycles", bsy, 2);
      check("lat0 load rdata", rd, 16'h0023);
      check("lat0 idle_after", aa, 1'b0);

      // Reset one cycle after acceptance of a store
      begin
         int nack;
         nack = 0;
         @(negedge clk);
         drive(1'b0, 1'b1, 1'b1, 16'd7, 16'h1234);
         @(negedge clk);
         @(negedge clk);
         rst = 1'b0;
         drive(1'b0, 1'b0, 1'b1, 16'd7, 16'h1234);
         #1;
         check("midrst busy", busy, 1'b0);
         check("midrst ack", ack, 1'b0);
         check("midrst rdata", rdata, 16'h0000);
         if (ack) nack++;
         repeat (2) begin
            @(negedge clk);
            if (ack) nack++;
         end
         rst = 1'b1;
         repeat (6) begin
            @(negedge clk);
            if (ack) nack++;
         end
         check("midrst no_ack", nack, 0);
         txn(1'b0, 1'b0, 16'd7, 16'h0000, rd, e, lat, bsy, aa);
         check("midrst load latency", lat, 4);
         check("midrst load rdata", rd, 16'h0000);
         check("midrst load err", e, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for CPU data loads and stores: a multi-cycle, handshaked data store with a configurable number of wait states.
- The CPU side asserts a request with address, direction and write data. The block holds DEPTH 16-bit words and completes each transaction with a one-cycle ack.
- Sits between the datapath load/store stage and storage, replacing the zero-latency combinational read path.

Parameters:
- DEPTH, 128, number of 16-bit words; power of two, 2..1024.
- LATENCY, 2, wait-state cycles before the access is performed; 0..15.
- DW, 16, data word width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-low.
- req  input  1  request, level; held with addr/we/wdata stable until ack seen.
- we  input  1  1=store, 0=load; sampled with req.
- addr  input  16  word address.
- wdata  input  DW  store data.
- ack  output  1  one-cycle completion pulse.
- rdata  output  DW  load data; valid while ack=1, held until next load completes.
- busy  output  1  high while in WAIT or RESP.
- err  output  1  error flag, qualified by ack; see Optional Feature.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0.
  - ack=0, rdata=0, busy=0, err=0.
  - All DEPTH words cleared to 0; latched request fields cleared.
  - Reset mid-transaction drops the pending access; no write occurs and no ack is produced.
- State IDLE:
  - busy=0, ack=0.
  - On an edge with req=1: latch addr, we, wdata; counter<=LATENCY; go to WAIT.
  - req=0: stay in IDLE.
- State WAIT:
  - busy=1.
  - On each edge with counter!=0: counter decrements.
  - On the edge with counter==0: perform the access and go to RESP.
    - Store: mem[index]<=latched wdata.
    - Load: rdata<=mem[index].
- State RESP:
  - ack=1 and busy=1 for exactly one cycle; next edge goes to IDLE unconditionally.
- Latency:
  - Acceptance edge E0; ack is high between edge E(LATENCY+1) and E(LATENCY+2).
  - Minimum spacing between acceptances: LATENCY+3 cycles.
  - A req still high in the IDLE cycle after ack starts a new transaction. The requester must drop req in the cycle ack is seen unless it intends back-to-back transactions.
- Inputs are ignored outside IDLE; changes to addr/we/wdata during WAIT/RESP have no effect.
- Index: addr[log2(DEPTH)-1:0]; upper address bits are ignored, so the address wraps modulo DEPTH.
- A store leaves rdata unchanged. A load of a word stored earlier returns the stored value, with no stale-data hazard since accesses are serialized.
- err=0 always when DMEM_OOR_ERR_EN is undefined.
- No simultaneous read/write hazard: one access per transaction.

Optional Feature:
- Macro: DMEM_OOR_ERR_EN.
- Defined:
  - addr >= DEPTH is out of range.
  - Out of range store: no write.
  - Out of range load: rdata<=0.
  - The transaction still completes with normal latency; err=1 during the ack cycle, 0 otherwise.
  - In-range accesses are unchanged.
- Undefined:
  - Address wraps modulo DEPTH; err tied to 0.

Test Plan:
- Reset then load:
  - rst low 2 cycles, release; load addr=5.
  - ack exactly 3 cycles after acceptance edge (LATENCY=2); rdata=0x0000; err=0.
- Store/load round trip:
  - store addr=10 wdata=0x97 89, then load addr=10.
  - rdata=0x9789 on ack; busy high 4 cycles per transaction; rdata unchanged during the store.
- Back-to-back with held req:
  - hold req=1 we=0 addr=3 across two transactions after storing 0x0031.
  - Two ack pulses spaced LATENCY+3=5 cycles apart, both rdata=0x0031.
- LATENCY=0 instance:
  - store addr=1 0x0023, load addr=1.
  - ack one cycle after acceptance; rdata=0x0023.
- Reset mid-WAIT:
  - start store addr=7 0x1234; assert rst one cycle after acceptance; release; load addr=7.
  - No ack from the aborted store; load returns 0x0000.
- Out-of-range address:
  - store addr=130 0xBEEF, then load addr=2.
  - Without macro: rdata=0xBEEF, err=0.
  - With DMEM_OOR_ERR_EN: the store's ack has err=1; load addr=2 returns 0x0000 with err=0; load addr=130 returns 0x0000 with err=1.
